// File: rtl/axi4_tlp_demux.sv
// Steers whole TLP packets from one de-straddled 512-bit AXI-Stream input to one of NUM_M
// master ports, chosen by the destination field in the first beat; out-of-range packets are discarded and counted.
module axi4_tlp_demux #(
    parameter int AXI_TUSER_L = 161,
    parameter int NUM_M       = 4,
    parameter int DEST_LSB    = 112,
    parameter int DEST_W      = 3
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [511:0]           S_AXIS_TDATA,
    input  logic [15:0]            S_AXIS_TKEEP,
    input  logic [AXI_TUSER_L-1:0] S_AXIS_TUSER,
    input  logic                   S_AXIS_TLAST,
    input  logic                   S_AXIS_TVALID,
    output logic                   S_AXIS_TREADY,
    output logic [511:0]           M_AXIS_TDATA,
    output logic [15:0]            M_AXIS_TKEEP,
    output logic [AXI_TUSER_L-1:0] M_AXIS_TUSER,
    output logic                   M_AXIS_TLAST,
    output logic [NUM_M-1:0]       M_AXIS_TVALID,
    input  logic [NUM_M-1:0]       M_AXIS_TREADY,
    output logic [15:0]            drop_count,
    output logic                   error_bad_dest
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // One bit wider than the field so NUM_M == 2**DEST_W still compares correctly.
    localparam logic [DEST_W:0] NUM_M_C = (DEST_W + 1)'(NUM_M);

    state_t                 state_r;
    logic [DEST_W-1:0]      cur_dest_r;
    logic [NUM_M-1:0]       m_valid_r;
    logic [511:0]           m_data_r;
    logic [15:0]            m_keep_r;
    logic [AXI_TUSER_L-1:0] m_user_r;
    logic                   m_last_r;
    logic [15:0]            drop_count_r;
    logic                   error_bad_dest_r;

    logic [DEST_W-1:0]      dest_s;
    logic                   dest_ok_s;
    logic [DEST_W-1:0]      load_dest_s;
    logic [NUM_M-1:0]       load_onehot_s;
    logic                   drain_s;
    logic                   s_ready_s;
    logic                   s_hs_s;
    logic                   fwd_s;
    logic                   drop_first_s;

    // First-beat decode, handshake qualification and one-hot destination for the output register.
    always_comb begin
        dest_s        = S_AXIS_TDATA[DEST_LSB +: DEST_W];
        dest_ok_s     = ({1'b0, dest_s} < NUM_M_C);
        drain_s       = |(m_valid_r & M_AXIS_TREADY);
        s_ready_s     = (state_r == ST_DROP) || (m_valid_r == '0) || drain_s;
        s_hs_s        = S_AXIS_TVALID && s_ready_s;
        fwd_s         = s_hs_s && (((state_r == ST_IDLE) && dest_ok_s) || (state_r == ST_FWD));
        drop_first_s  = s_hs_s && (state_r == ST_IDLE) && !dest_ok_s;
        load_onehot_s = '0;
        if (state_r == ST_IDLE) begin
            load_dest_s = dest_s;
        end else begin
            load_dest_s = cur_dest_r;
        end
        for (int i = 0; i < NUM_M; i++) begin
            if (load_dest_s == DEST_W'(i)) begin
                load_onehot_s[i] = 1'b1;
            end else begin
                load_onehot_s[i] = 1'b0;
            end
        end
    end

    // Packet state machine, output register stage and drop accounting.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r          <= ST_IDLE;
            cur_dest_r       <= '0;
            m_valid_r        <= '0;
            m_data_r         <= '0;
            m_keep_r         <= '0;
            m_user_r         <= '0;
            m_last_r         <= 1'b0;
            drop_count_r     <= 16'd0;
            error_bad_dest_r <= 1'b0;
        end else begin
            if (fwd_s) begin
                m_valid_r <= load_onehot_s;
                m_data_r  <= S_AXIS_TDATA;
                m_keep_r  <= S_AXIS_TKEEP;
                m_user_r  <= S_AXIS_TUSER;
                m_last_r  <= S_AXIS_TLAST;
            end else if (drain_s) begin
                m_valid_r <= '0;
            end
            error_bad_dest_r <= drop_first_s;
            if (drop_first_s && (drop_count_r != 16'hFFFF)) begin
                drop_count_r <= drop_count_r + 16'd1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (s_hs_s) begin
                        if (dest_ok_s) begin
                            cur_dest_r <= dest_s;
                            state_r    <= S_AXIS_TLAST ? ST_IDLE : ST_FWD;
                        end else begin
                            state_r    <= S_AXIS_TLAST ? ST_IDLE : ST_DROP;
                        end
                    end
                end
                ST_FWD, ST_DROP: begin
                    if (s_hs_s && S_AXIS_TLAST) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign S_AXIS_TREADY  = s_ready_s;
    assign M_AXIS_TVALID  = m_valid_r;
    assign M_AXIS_TDATA   = m_data_r;
    assign M_AXIS_TKEEP   = m_keep_r;
    assign M_AXIS_TUSER   = m_user_r;
    assign M_AXIS_TLAST   = m_last_r;
    assign drop_count     = drop_count_r;
    assign error_bad_dest = error_bad_dest_r;

endmodule

// File: tb/tb_axi4_tlp_demux.sv
// Directed bench for axi4_tlp_demux: expected output beats are queued when input beats are
// accepted and compared against the master side on every output handshake.
module tb_axi4_tlp_demux;

    localparam int UL = 161;

    logic           ACLK = 1'b0;
    logic           ARESET;
    logic [511:0]   S_AXIS_TDATA;
    logic [15:0]    S_AXIS_TKEEP;
    logic [UL-1:0]  S_AXIS_TUSER;
    logic           S_AXIS_TLAST;
    logic           S_AXIS_TVALID;
    logic           S_AXIS_TREADY;
    logic [511:0]   M_AXIS_TDATA;
    logic [15:0]    M_AXIS_TKEEP;
    logic [UL-1:0]  M_AXIS_TUSER;
    logic           M_AXIS_TLAST;
    logic [3:0]     M_AXIS_TVALID;
    logic [3:0]     M_AXIS_TREADY;
    logic [15:0]    drop_count;
    logic           error_bad_dest;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [13:0] exp_q[$];   // {onehot valid, data byte, last, tuser[96]}

    axi4_tlp_demux #(.AXI_TUSER_L(UL), .NUM_M(4), .DEST_LSB(112), .DEST_W(3)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TKEEP(S_AXIS_TKEEP), .S_AXIS_TUSER(S_AXIS_TUSER),
        .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TUSER(M_AXIS_TUSER),
        .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
        .drop_count(drop_count), .error_bad_dest(error_bad_dest)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive(input logic [2:0] dfield, input logic [7:0] b, input logic last);
        S_AXIS_TDATA             = '0;
        S_AXIS_TDATA[7:0]        = b;
        S_AXIS_TDATA[114:112]    = dfield;
        S_AXIS_TKEEP             = 16'hFFFF;
        S_AXIS_TUSER             = '0;
        S_AXIS_TUSER[96]         = b[0];
        S_AXIS_TLAST             = last;
        S_AXIS_TVALID            = 1'b1;
    endtask

    // Drives one beat until accepted; exp_vld is the port it must appear on (zero if dropped).
    task automatic send_beat(input logic [2:0] dfield, input logic [3:0] exp_vld,
                             input logic [7:0] b, input logic last, output int waits);
        waits = 0;
        drive(dfield, b, last);
        @(negedge ACLK);
        while (!S_AXIS_TREADY && waits < 50) begin
            waits++;
            @(negedge ACLK);
        end
        if (waits >= 50) begin
            check("accept_timeout", 64'(waits), 64'd0);
        end
        if (exp_vld != 4'd0) begin
            exp_q.push_back({exp_vld, b, last, b[0]});
        end
        tick();
        S_AXIS_TVALID = 1'b0;
    endtask

    // Output monitor: every master handshake must match the head of the scoreboard.
    always @(negedge ACLK) begin
        if (!ARESET && ((M_AXIS_TVALID & M_AXIS_TREADY) != 4'd0)) begin
            check("mon_expected_beat", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check("mon_beat", 64'({M_AXIS_TVALID, M_AXIS_TDATA[7:0], M_AXIS_TLAST, M_AXIS_TUSER[96]}),
                      64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int w;
        int wsum;
        ARESET        = 1'b1;
        M_AXIS_TREADY = 4'hF;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TKEEP  = '0;
        S_AXIS_TUSER  = '0;
        S_AXIS_TLAST  = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        check("rst_tready", 64'(S_AXIS_TREADY), 64'd1);
        check("rst_err", 64'(error_bad_dest), 64'd0);
        check("rst_tdata", 64'(M_AXIS_TDATA[63:0]), 64'd0);
        ARESET = 1'b0;
        tick();

        // Two-beat forward to port 2; second beat carries a misleading descriptor
        send_beat(3'd2, 4'b0100, 8'hAA, 1'b0, w);
        check("fwd_lat_b0_valid", 64'(M_AXIS_TVALID), 64'b0100);
        check("fwd_lat_b0_data", 64'(M_AXIS_TDATA[7:0]), 64'hAA);
        send_beat(3'd6, 4'b0100, 8'hBB, 1'b1, w);
        check("fwd_lat_b1_valid", 64'(M_AXIS_TVALID), 64'b0100);
        check("fwd_lat_b1_last", 64'(M_AXIS_TLAST), 64'd1);
        tick();
        check("fwd_idle_valid", 64'(M_AXIS_TVALID), 64'd0);

        // Back-to-back packets to different ports, no bubble
        wsum = 0;
        send_beat(3'd0, 4'b0001, 8'h01, 1'b1, w); wsum += w;
        check("b2b_p0_valid", 64'(M_AXIS_TVALID), 64'b0001);
        send_beat(3'd3, 4'b1000, 8'h31, 1'b0, w); wsum += w;
        check("b2b_p3a_valid", 64'(M_AXIS_TVALID), 64'b1000);
        send_beat(3'd6, 4'b1000, 8'h32, 1'b1, w); wsum += w;
        check("b2b_p3b_valid", 64'(M_AXIS_TVALID), 64'b1000);
        check("b2b_no_stall", 64'(wsum), 64'd0);
        tick();

        // Drop 3-beat packet with dest 5 while all masters back-pressure
        M_AXIS_TREADY = 4'h0;
        wsum = 0;
        send_beat(3'd5, 4'd0, 8'h50, 1'b0, w); wsum += w;
        check("drop_err_pulse", 64'(error_bad_dest), 64'd1);
        check("drop_no_valid0", 64'(M_AXIS_TVALID), 64'd0);
        send_beat(3'd1, 4'd0, 8'h51, 1'b0, w); wsum += w;
        check("drop_err_once", 64'(error_bad_dest), 64'd0);
        send_beat(3'd0, 4'd0, 8'h52, 1'b1, w); wsum += w;
        check("drop_rate", 64'(wsum), 64'd0);
        check("drop_no_valid", 64'(M_AXIS_TVALID), 64'd0);
        check("drop_count_1", 64'(drop_count), 64'd1);

        // Held output beat must drain before a bad-destination beat is accepted
        send_beat(3'd1, 4'b0010, 8'h61, 1'b1, w);
        drive(3'd7, 8'h62, 1'b1);
        repeat (2) begin
            @(negedge ACLK);
            check("drain_first_ready", 64'(S_AXIS_TREADY), 64'd0);
            tick();
        end
        check("drain_first_count", 64'(drop_count), 64'd1);
        M_AXIS_TREADY = 4'hF;
        @(negedge ACLK);
        check("drain_then_ready", 64'(S_AXIS_TREADY), 64'd1);
        tick();
        S_AXIS_TVALID = 1'b0;
        check("drain_drop_count", 64'(drop_count), 64'd2);
        check("drain_drop_err", 64'(error_bad_dest), 64'd1);
        tick();

        // Back-pressure mid-packet on port 1
        send_beat(3'd1, 4'b0010, 8'h10, 1'b0, w);
        M_AXIS_TREADY = 4'b1101;
        drive(3'd1, 8'h11, 1'b0);
        repeat (3) begin
            @(negedge ACLK);
            check("bp_sready", 64'(S_AXIS_TREADY), 64'd0);
            check("bp_hold", 64'({M_AXIS_TVALID, M_AXIS_TDATA[7:0]}), 64'h210);
            tick();
        end
        M_AXIS_TREADY = 4'hF;
        send_beat(3'd1, 4'b0010, 8'h11, 1'b0, w);
        send_beat(3'd1, 4'b0010, 8'h12, 1'b1, w);
        tick();

        // Reset mid-packet: only the packet after reset appears
        M_AXIS_TREADY = 4'h0;
        send_beat(3'd0, 4'd0, 8'h30, 1'b0, w);
        ARESET = 1'b1;
        repeat (2) tick();
        ARESET = 1'b0;
        check("mrst_valid", 64'(M_AXIS_TVALID), 64'd0);
        check("mrst_ready", 64'(S_AXIS_TREADY), 64'd1);
        M_AXIS_TREADY = 4'hF;
        send_beat(3'd1, 4'b0010, 8'h77, 1'b1, w);
        check("mrst_new_pkt", 64'({M_AXIS_TVALID, M_AXIS_TLAST}), 64'b00101);
        repeat (3) tick();
        check("mrst_no_stale", 64'(M_AXIS_TVALID), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
